// File: rtl/mult_execution_unit.sv
// -----------------------------------------------------------------------------
// mult_execution_unit
//
// Pipelined RV32M multiply execution unit for the out-of-order core. Accepts
// one ready multiply per cycle from its reservation station, carries the ROB
// tag alongside the operation, and presents the result to the CDB arbiter
// under a valid/ready handshake. The whole pipeline advances together
// whenever the output is empty or being taken, and holds otherwise.
//
// Each stage adds the partial product of one XLEN/STAGES-bit chunk of the
// (extended) opb. The last chunk is signed, so the accumulated sum is the
// exact signed (XLEN+1)x(XLEN+1)-bit product of the extended operands.
//
// Optional feature macro: MULT_SQUASH_EN
//   defined   : squash forces out_valid low, blocks the same-cycle accept and
//               clears every valid bit at the next edge.
//   undefined : squash is ignored; the ROB discards wrong-path results.
//
// Parameters:
//   XLEN   operand/result width (divisible by STAGES)
//   STAGES pipeline depth, 1..8
//   TAG_W  ROB tag width
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   in_valid     RS presents a ready multiply
//   in_ready     unit accepts this cycle (depends on output state only)
//   opa, opb     rs1 / rs2 values
//   func         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_rob_tag   destination ROB tag
//   squash       mispredict flush
//   out_valid    result available for the CDB
//   out_ready    CDB grant
//   out_value    result
//   out_rob_tag  tag of the result
// -----------------------------------------------------------------------------
module mult_execution_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [1:0]       func,
    input  logic [TAG_W-1:0] in_rob_tag,
    input  logic             squash,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_value,
    output logic [TAG_W-1:0] out_rob_tag
);

    localparam int CW = XLEN / STAGES;   // opb chunk width per stage
    localparam int PW = 2 * XLEN + 2;    // partial-sum width

    typedef enum logic [1:0] {
        FUNC_MUL    = 2'b00,
        FUNC_MULH   = 2'b01,
        FUNC_MULHSU = 2'b10,
        FUNC_MULHU  = 2'b11
    } func_e;

    // Signed (XLEN+1)x(CW+1) product, sign-extended to the partial-sum width.
    function automatic logic [PW-1:0] partial_product(input logic [XLEN:0] a,
                                                      input logic [CW:0]   c);
        logic [PW-1:0] a_x;
        logic [PW-1:0] c_x;
        a_x = {{(PW-XLEN-1){a[XLEN]}}, a};
        c_x = {{(PW-CW-1){c[CW]}}, c};
        return a_x * c_x;
    endfunction

    // Low chunk of the remaining opb; only the top chunk carries the sign bit.
    function automatic logic [CW:0] opb_chunk(input logic [XLEN:0] x,
                                              input logic          last);
        return {last & x[CW], x[CW-1:0]};
    endfunction

    // Arithmetic shift that drops the consumed chunk.
    function automatic logic [XLEN:0] opb_rest(input logic [XLEN:0] x);
        return {{CW{x[XLEN]}}, x[XLEN:CW]};
    endfunction

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q,   tag_d;
    logic [STAGES-1:0][1:0]        func_q,  func_d;
    logic [STAGES-1:0][XLEN:0]     a_q,     a_d;
    logic [STAGES-1:0][XLEN:0]     b_q,     b_d;
    logic [STAGES-1:0][PW-1:0]     sum_q,   sum_d;

    logic            squash_s;
    logic            advance_s;
    logic            accept_s;
    logic [XLEN:0]   a_ext_s;
    logic [XLEN:0]   b_ext_s;
    logic [PW-1:0]   product_s;
    logic            unused_s;

`ifdef MULT_SQUASH_EN
    assign squash_s = squash;
`else
    logic unused_squash_s;
    assign unused_squash_s = squash;
    assign squash_s        = 1'b0;
`endif

    // The last stage's operand copies are never consumed, nor are the
    // product bits above 2*XLEN.
    assign unused_s = ^{a_q[STAGES-1], b_q[STAGES-1], product_s[PW-1:2*XLEN]};

    assign product_s   = sum_q[STAGES-1];
    assign out_valid   = valid_q[STAGES-1] & ~squash_s;
    assign advance_s   = ~out_valid | out_ready;
    assign in_ready    = advance_s;
    assign accept_s    = in_valid & advance_s & ~squash_s;
    assign out_rob_tag = tag_q[STAGES-1];

    // Operand extension and result selection.
    always_comb begin
        a_ext_s   = {opa[XLEN-1] & ((func == FUNC_MULH) || (func == FUNC_MULHSU)), opa};
        b_ext_s   = {opb[XLEN-1] & (func == FUNC_MULH), opb};
        out_value = product_s[2*XLEN-1:XLEN];
        if (func_q[STAGES-1] == FUNC_MUL) begin
            out_value = product_s[XLEN-1:0];
        end else begin
            out_value = product_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state for every stage: shift together on advance, hold otherwise.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        if (advance_s) begin
            // Bubble enters stage 0 when nothing is accepted.
            valid_d[0] = accept_s;
            tag_d[0]   = in_rob_tag;
            func_d[0]  = func;
            a_d[0]     = a_ext_s;
            b_d[0]     = opb_rest(b_ext_s);
            sum_d[0]   = partial_product(a_ext_s,
                                         opb_chunk(b_ext_s, (STAGES == 1) ? 1'b1 : 1'b0));
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                tag_d[k]   = tag_q[k-1];
                func_d[k]  = func_q[k-1];
                a_d[k]     = a_q[k-1];
                b_d[k]     = opb_rest(b_q[k-1]);
                sum_d[k]   = sum_q[k-1]
                           + (partial_product(a_q[k-1],
                                              opb_chunk(b_q[k-1], (k == STAGES - 1) ? 1'b1 : 1'b0))
                              << (k * CW));
            end
        end else begin
            valid_d = valid_q;
        end
        if (squash_s) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Valid bits: the only state that needs reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data path registers; contents are don't-care while the valid bit is low.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        func_q <= func_d;
        a_q    <= a_d;
        b_q    <= b_d;
        sum_q  <= sum_d;
    end

endmodule

// File: tb/tb_mult_execution_unit.sv
module tb_mult_execution_unit;

    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 5;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [1:0]       func;
    logic [TAG_W-1:0] in_rob_tag;
    logic             squash;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_value;
    logic [TAG_W-1:0] out_rob_tag;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;

    mult_execution_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opa        (opa),
        .opb        (opb),
        .func       (func),
        .in_rob_tag (in_rob_tag),
        .squash     (squash),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_rob_tag(out_rob_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: full 64-bit multiply of the extended operands.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] f);
        logic [63:0] ea, eb, p;
        ea = ((f == 2'b01) || (f == 2'b10)) ? {{32{a[31]}}, a} : {32'h0000_0000, a};
        eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'h0000_0000, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] f, input logic [TAG_W-1:0] t);
        in_valid   = 1'b1;
        opa        = a;
        opb        = b;
        func       = f;
        in_rob_tag = t;
        sync();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: pop on each CDB transfer, push on each accept.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
        end
`ifdef MULT_SQUASH_EN
        else if (squash) begin
            exp_q.delete();
        end
`endif
        else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_value", {32'd0, out_value}, {32'd0, e.value});
                    check("sb_tag", {59'd0, out_rob_tag}, {59'd0, e.tag});
                end
            end
            if (in_valid && in_ready) begin
                e.tag   = in_rob_tag;
                e.value = ref_mul(opa, opb, func);
                exp_q.push_back(e);
                n_acc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_vals [4];
        logic [31:0] stall_val;
        int cycles;
        int start_acc;

        reset = 1'b0; in_valid = 1'b0; opa = '0; opb = '0; func = 2'b00;
        in_rob_tag = '0; squash = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Single MULHU latency
        sync();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("latency_out_valid", {63'd0, out_valid}, (i == 3) ? 64'd1 : 64'd0);
        end
        check("mulhu_value", {32'd0, out_value}, 64'h0000_0000_FFFF_FFFE);
        check("mulhu_tag", {59'd0, out_rob_tag}, 64'd3);

        // Back-to-back ops
        sync();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd10);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd11);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd12);
        issue(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd13);
        in_valid = 1'b0;
        exp_vals[0] = 32'h0000_0001; exp_vals[1] = 32'h0000_0000;
        exp_vals[2] = 32'hFFFF_FFFF; exp_vals[3] = 32'h4000_0000;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check("b2b_valid", {63'd0, out_valid}, 64'd1);
            check("b2b_value", {32'd0, out_value}, {32'd0, exp_vals[j]});
            check("b2b_tag", {59'd0, out_rob_tag}, 64'd10 + 64'(j));
        end
        @(negedge clock);
        check("b2b_idle_after", {63'd0, out_valid}, 64'd0);

        // Output stall for three cycles
        sync();
        issue(32'h0000_0003, 32'h0000_0005, 2'b00, 5'd20);
        issue(32'h8000_0000, 32'h0000_0004, 2'b11, 5'd21);
        issue(32'h1234_5678, 32'h0000_0010, 2'b00, 5'd22);
        issue(32'hFFFF_FFFE, 32'h0000_0003, 2'b01, 5'd23);
        out_ready = 1'b0;
        in_valid = 1'b1; opa = 32'h8000_0000; opb = 32'hFFFF_FFFF; func = 2'b10; in_rob_tag = 5'd24;
        stall_val = ref_mul(32'h0000_0003, 32'h0000_0005, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_value", {32'd0, out_value}, {32'd0, stall_val});
            check("stall_tag", {59'd0, out_rob_tag}, 64'd20);
            sync();
        end
        out_ready = 1'b1;
        sync();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) sync();
        check("stall_drain", 64'(exp_q.size()), 64'd0);

        // Squash
        sync();
`ifdef MULT_SQUASH_EN
        issue(32'h0000_0007, 32'h0000_0009, 2'b00, 5'd1);
        issue(32'h0000_0007, 32'h0000_0009, 2'b00, 5'd2);
        issue(32'h0000_0007, 32'h0000_0009, 2'b00, 5'd3);
        issue(32'h0000_0007, 32'h0000_0009, 2'b00, 5'd4);
        squash = 1'b1; in_valid = 1'b1; in_rob_tag = 5'd5;
        @(negedge clock);
        check("squash_out_valid", {63'd0, out_valid}, 64'd0);
        check("squash_in_ready", {63'd0, in_ready}, 64'd1);
        sync();
        squash = 1'b0;
`else
        squash = 1'b1;
`endif
        issue(32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 5'd7);
        in_valid = 1'b0; squash = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_squash_valid", {63'd0, out_valid}, (i == 3) ? 64'd1 : 64'd0);
        end
        check("post_squash_tag", {59'd0, out_rob_tag}, 64'd7);
        check("post_squash_value", {32'd0, out_value}, 64'd1);
        @(negedge clock);
        check("post_squash_idle", {63'd0, out_valid}, 64'd0);

        // Reset with four ops in flight
        sync();
        issue(32'h0000_0011, 32'h0000_0022, 2'b00, 5'd8);
        issue(32'h0000_0011, 32'h0000_0022, 2'b00, 5'd9);
        issue(32'h0000_0011, 32'h0000_0022, 2'b00, 5'd10);
        issue(32'h0000_0011, 32'h0000_0022, 2'b00, 5'd11);
        in_valid = 1'b0;
        reset = 1'b0;
        sync();
        reset = 1'b1;
        @(negedge clock);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("midreset_no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Random traffic with random backpressure
        start_acc = n_acc;
        cycles = 0;
        while ((n_acc - start_acc) < 10000 && cycles < 60000) begin
            sync();
            in_valid   = ($urandom_range(0, 3) != 0);
            opa        = pick_operand();
            opb        = pick_operand();
            func       = 2'($urandom_range(0, 3));
            in_rob_tag = TAG_W'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("random_budget", {63'd0, cycles < 60000}, 64'd1);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) sync();
        check("random_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
